// File: rtl/oversample_tx.sv
// Transmit oversampler: repeats each accepted AXI-Stream bit OVS_FACTOR times on the output
// stream, with optional idle gap cycles after each symbol.
module oversample_tx #(
    parameter int OVS_FACTOR = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_tvalid,
    output logic s_tready,
    input  logic s_tdata,
    input  logic s_tlast,
    output logic m_tvalid,
    input  logic m_tready,
    output logic m_tdata,
    output logic m_tlast,
    output logic busy,
    output logic frame_done
);

    localparam int REP_W = (OVS_FACTOR > 2) ? $clog2(OVS_FACTOR) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(OVS_FACTOR - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]       state;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             bit_q;
    logic             last_q;
    logic             m_hs;
    logic             sym_end;
    logic             accept;

    assign m_tvalid = (state == SEND);
    assign m_tdata  = m_tvalid & bit_q;
    assign m_tlast  = m_tvalid & last_q & (rep_cnt == REP_LAST);
    assign busy     = (state != IDLE);
    assign m_hs     = m_tvalid & m_tready;
    assign sym_end  = m_hs & (rep_cnt == REP_LAST);

    // Gated by rst_n so nothing is advertised while reset is held.
    assign s_tready = rst_n & ((state == IDLE) | ((GAP_CYCLES == 0) & sym_end));
    assign accept   = s_tvalid & s_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
            bit_q      <= 1'b0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= m_hs & m_tlast;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bit_q   <= s_tdata;
                        last_q  <= s_tlast;
                        rep_cnt <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (m_hs) begin
                        if (rep_cnt == REP_LAST) begin
                            rep_cnt <= '0;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end else if (accept) begin
                                // back-to-back: next symbol starts with no idle cycle
                                bit_q  <= s_tdata;
                                last_q <= s_tlast;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oversample_tx.sv
// Directed bench for oversample_tx: one back-to-back instance and one with a 2-cycle gap.
module tb_oversample_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic s_tvalid = 0, s_tdata = 0, s_tlast = 0, m_tready = 0;
    logic s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done;

    logic g_s_tvalid = 0, g_s_tdata = 0, g_s_tlast = 0, g_m_tready = 0;
    logic g_s_tready, g_m_tvalid, g_m_tdata, g_m_tlast, g_busy, g_frame_done;

    int checks = 0;
    int errors = 0;

    oversample_tx #(.OVS_FACTOR(4), .GAP_CYCLES(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .busy(busy), .frame_done(frame_done)
    );

    oversample_tx #(.OVS_FACTOR(4), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(g_s_tvalid), .s_tready(g_s_tready), .s_tdata(g_s_tdata), .s_tlast(g_s_tlast),
        .m_tvalid(g_m_tvalid), .m_tready(g_m_tready), .m_tdata(g_m_tdata), .m_tlast(g_m_tlast),
        .busy(g_busy), .frame_done(g_frame_done)
    );

    // Sends nb bits (MSB of bits first) and records every output sample in data/last[15:0].
    task automatic drive_frame(input logic [3:0] bits, input int nb, input bit toggle,
                               output logic [15:0] data, output logic [15:0] last,
                               output int cnt, output int stall_err, output int rdy_err,
                               output int gaps, output logic fd);
        int i = 0;
        int cyc = 0;
        bit hold = 0;
        bit started = 0;
        logic hd = 0, hl = 0;
        data = '0; last = '0; cnt = 0; stall_err = 0; rdy_err = 0; gaps = 0; fd = 0;
        while (cnt < 4 * nb && cyc < 200) begin
            @(negedge clk);
            s_tvalid = (i < nb);
            s_tdata  = (i < 4) ? bits[2'(3 - i)] : 1'b0;
            s_tlast  = (i == nb - 1);
            m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (hold && !(m_tvalid && m_tdata === hd && m_tlast === hl)) stall_err++;
            hold = m_tvalid && !m_tready;
            hd = m_tdata;
            hl = m_tlast;
            if (started && !m_tvalid) gaps++;
            if (s_tready && m_tvalid && (cnt % 4) != 3) rdy_err++;
            if (m_tvalid && m_tready) begin
                data[15 - cnt] = m_tdata;
                last[15 - cnt] = m_tlast;
                cnt++;
            end
            if (s_tvalid && s_tready) begin
                i++;
                started = 1;
            end
            cyc++;
        end
        @(negedge clk);
        s_tvalid = 0; s_tlast = 0; s_tdata = 0; m_tready = 0;
        #1;
        fd = frame_done;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_held: got %b want 000000",
                     {s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done});
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if ({s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_release: got %b want 100000",
                     {s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done});
        end
        checks++;
        if ({g_s_tready, g_m_tvalid, g_busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_gap_inst: got %b want 100", {g_s_tready, g_m_tvalid, g_busy});
        end
    endtask

    task automatic test_basic();
        logic [15:0] d, l; int c, se, re, gp; logic fd;
        drive_frame(4'b1011, 4, 0, d, l, c, se, re, gp, fd);
        checks++;
        if (c !== 16) begin errors++; $display("FAIL basic_count: got %0d want 16", c); end
        checks++;
        if (d !== 16'hF0FF) begin errors++; $display("FAIL basic_data: got %h want f0ff", d); end
        checks++;
        if (l !== 16'h0001) begin errors++; $display("FAIL basic_last: got %h want 0001", l); end
        checks++;
        if (gp !== 0) begin errors++; $display("FAIL basic_gaps: got %0d want 0", gp); end
        checks++;
        if (fd !== 1'b1) begin errors++; $display("FAIL basic_frame_done: got %b want 1", fd); end
        #5;
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d, l; int c, se, re, gp; logic fd;
        drive_frame(4'b1011, 4, 1, d, l, c, se, re, gp, fd);
        checks++;
        if (d !== 16'hF0FF || c !== 16) begin
            errors++; $display("FAIL bp_data: got %h/%0d want f0ff/16", d, c);
        end
        checks++;
        if (l !== 16'h0001) begin errors++; $display("FAIL bp_last: got %h want 0001", l); end
        checks++;
        if (se !== 0) begin errors++; $display("FAIL bp_stability: got %0d unstable stalls want 0", se); end
        checks++;
        if (fd !== 1'b1) begin errors++; $display("FAIL bp_frame_done: got %b want 1", fd); end
    endtask

    task automatic test_gap();
        int i = 0;
        logic [11:0] mv, sr, bz, md, ml;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g_s_tvalid = (i < 2); g_s_tdata = 1; g_s_tlast = (i == 1); g_m_tready = 1;
            #1;
            mv[11 - c] = g_m_tvalid; sr[11 - c] = g_s_tready; bz[11 - c] = g_busy;
            md[11 - c] = g_m_tdata;  ml[11 - c] = g_m_tlast;
            if (g_s_tvalid && g_s_tready) i++;
        end
        @(negedge clk);
        g_s_tvalid = 0; g_s_tlast = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (mv !== 12'h78F) begin errors++; $display("FAIL gap_valid: got %h want 78f", mv); end
        checks++;
        if (sr !== 12'h810) begin errors++; $display("FAIL gap_ready: got %h want 810", sr); end
        checks++;
        if (bz !== 12'h7EF) begin errors++; $display("FAIL gap_busy: got %h want 7ef", bz); end
        checks++;
        if (md !== 12'h78F || ml !== 12'h001) begin
            errors++; $display("FAIL gap_data_last: got %h/%h want 78f/001", md, ml);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, l; int c, se, re, gp; logic fd;
        @(negedge clk);
        s_tvalid = 1; s_tdata = 1; s_tlast = 0; m_tready = 1;
        @(negedge clk);
        s_tvalid = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done} !== 6'b000000) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want 000000",
                     {s_tready, m_tvalid, m_tdata, m_tlast, busy, frame_done});
        end
        @(negedge clk);
        rst_n = 1;
        drive_frame(4'b0000, 1, 0, d, l, c, se, re, gp, fd);
        checks++;
        if (c !== 4 || d !== 16'h0000) begin
            errors++; $display("FAIL midrst_data: got %h/%0d want 0000/4", d, c);
        end
        checks++;
        if (l !== 16'h1000) begin errors++; $display("FAIL midrst_last: got %h want 1000", l); end
        checks++;
        if (fd !== 1'b1) begin errors++; $display("FAIL midrst_frame_done: got %b want 1", fd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, l; int c, se, re, gp; logic fd;
        drive_frame(4'b0101, 4, 0, d, l, c, se, re, gp, fd);
        checks++;
        if (d !== 16'h0F0F || c !== 16) begin
            errors++; $display("FAIL b2b_data: got %h/%0d want 0f0f/16", d, c);
        end
        checks++;
        if (re !== 0) begin errors++; $display("FAIL b2b_ready_timing: got %0d early readies want 0", re); end
        checks++;
        if (gp !== 0) begin errors++; $display("FAIL b2b_idle: got %0d idle cycles want 0", gp); end
    endtask

    task automatic test_loopback();
        logic [15:0] d, l; int c, se, re, gp; logic fd;
        logic [3:0] nib, rec, grp;
        for (int n = 0; n < 16; n++) begin
            nib = 4'($urandom_range(0, 15));
            drive_frame(nib, 4, n[0], d, l, c, se, re, gp, fd);
            for (int k = 0; k < 4; k++) begin
                grp = d[15 - 4 * k -: 4];
                // even frames: majority vote; odd frames: Hamming weight above half
                rec[3 - k] = n[0] ? ($countones(grp) > 2) : ($countones(grp) >= 3);
            end
            checks++;
            if (rec !== nib || c !== 16) begin
                errors++; $display("FAIL loopback_%0d: got %h want %h (%0d samples)", n, rec, nib, c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
